// File: rtl/atomic_unit.sv
// RV32A sequencer for the MEM stage: owns the data-memory port for the
// LR/SC/AMO read-compute-write sequence and tracks the single LR reservation.
module atomic_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              is_atomic_mem,
    input  logic [4:0]        funct5_mem,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] rs2_mem_data,
    input  logic              store_mem,
    input  logic              trap,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              atomic_unit_stall,
    output logic [DATA_W-1:0] atomic_result,
    output logic              done,
    output logic              misaligned,
    output logic              illegal
);
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    logic [4:0]        funct5_q;
    logic [ADDR_W-3:0] word_q;
    logic [DATA_W-1:0] rs2_q;
    logic [DATA_W-1:0] old_q;
    logic              misaligned_q;
    logic              illegal_q;
    logic              resv_valid;
    logic [ADDR_W-3:0] resv_word;

    logic start_legal;
    logic start_misaligned;
    logic sc_hit;
    logic in_read;
    logic in_write;
    logic in_done;

    function automatic logic is_legal(input logic [4:0] f);
        case (f)
            F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
            F_MIN, F_MAX, F_MINU, F_MAXU: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] amo_calc(input logic [4:0] f,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        case (f)
            F_ADD:   return a + b;
            F_XOR:   return a ^ b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_MIN:   return ($signed(a) < $signed(b)) ? a : b;
            F_MAX:   return ($signed(a) > $signed(b)) ? a : b;
            F_MINU:  return (a < b) ? a : b;
            F_MAXU:  return (a > b) ? a : b;
            default: return b;
        endcase
    endfunction

    assign start_legal      = is_legal(funct5_mem);
    assign start_misaligned = (addr_mem[1:0] != 2'b00);
    assign sc_hit           = resv_valid && (resv_word == addr_mem[ADDR_W-1:2]);

    assign in_read  = (state == READ);
    assign in_write = (state == WRITE);
    assign in_done  = (state == DONE);

    // Bus fields are forced to zero whenever no request is outstanding.
    assign dmem_req   = in_read | in_write;
    assign dmem_we    = in_write;
    assign dmem_addr  = dmem_req ? {word_q, 2'b00} : '0;
    assign dmem_wdata = in_write ? ((funct5_q == F_SC) ? rs2_q : amo_calc(funct5_q, old_q, rs2_q))
                                 : '0;

    assign atomic_unit_stall = ((state == IDLE) && is_atomic_mem) | in_read | in_write;
    assign done              = in_done;
    assign atomic_result     = in_done ? old_q : '0;
    assign misaligned        = in_done & misaligned_q;
    assign illegal           = in_done & illegal_q;

    // old_q doubles as the rd value: read data for LR/AMO, 0/1 for SC, 0 for faults.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            funct5_q     <= '0;
            word_q       <= '0;
            rs2_q        <= '0;
            old_q        <= '0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            resv_valid   <= 1'b0;
            resv_word    <= '0;
        end else begin
            if (trap) begin
                resv_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (store_mem && resv_valid && (addr_mem[ADDR_W-1:2] == resv_word)) begin
                        resv_valid <= 1'b0;
                    end
                    if (is_atomic_mem && !trap) begin
                        funct5_q     <= funct5_mem;
                        word_q       <= addr_mem[ADDR_W-1:2];
                        rs2_q        <= rs2_mem_data;
                        old_q        <= '0;
                        misaligned_q <= start_misaligned;
                        illegal_q    <= !start_legal;
                        if (funct5_mem == F_SC) begin
                            resv_valid <= 1'b0;
                        end
                        if (!start_legal || start_misaligned) begin
                            state <= DONE;
                        end else if (funct5_mem == F_SC) begin
                            if (sc_hit) begin
                                state <= WRITE;
                            end else begin
                                old_q <= {{(DATA_W-1){1'b0}}, 1'b1};
                                state <= DONE;
                            end
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (trap) begin
                        state <= IDLE;
                    end else if (dmem_ack) begin
                        old_q <= dmem_rdata;
                        if (funct5_q == F_LR) begin
                            resv_valid <= 1'b1;
                            resv_word  <= word_q;
                            state      <= DONE;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (dmem_ack) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
